// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the core's data port. It services single-cycle
// load/store requests against a 64-bit-wide word array:
//   - loads are combinational (zero latency)
//   - stores commit at the next rising clock edge
//   - data is steered onto byte lanes by access size and address offset
//   - misaligned or out-of-range accesses raise a sticky fault, and the
//     first faulting access is captured
//
// Optional feature: define DMEM_PERF_CNT_EN to enable saturating counters of
// accepted loads and stores. When the macro is undefined, rd_cnt_o and
// wr_cnt_o are tied to zero and no counter flops exist.
//
// Ports:
//   clk                 clock
//   reset_n             asynchronous active-low reset (fault state, counters)
//   data_mem_req_i      access request this cycle
//   data_mem_addr_i     byte address
//   data_mem_byte_en_i  size code: 00=byte 01=half 10=word 11=dword
//   data_mem_wr_i       1=store, 0=load
//   data_mem_wr_data_i  store data, right-justified
//   data_mem_rd_data_o  load data, right-justified, upper bits zero
//   fault_o             sticky fault flag
//   fault_addr_o        address of the first faulting access
//   fault_wr_o          first faulting access was a store
//   rd_cnt_o            accepted-load counter (optional feature)
//   wr_cnt_o            accepted-store counter (optional feature)
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0001_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_mem_req_i,
    input  logic [63:0] data_mem_addr_i,
    input  logic [1:0]  data_mem_byte_en_i,
    input  logic        data_mem_wr_i,
    input  logic [63:0] data_mem_wr_data_i,
    output logic [63:0] data_mem_rd_data_o,
    output logic        fault_o,
    output logic [63:0] fault_addr_o,
    output logic        fault_wr_o,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

    logic [63:0] mem_q [DEPTH];

    logic [63:0] off;
    logic [AW-1:0] index;
    logic [2:0]  lane;
    logic        in_range;
    logic        aligned;
    logic        valid;
    logic        load_valid;
    logic        store_valid;
    logic        fault_event;
    logic [63:0] size_mask;
    logic [7:0]  size_be;
    logic [7:0]  wr_be;
    logic [63:0] wr_shifted;
    logic [63:0] rd_shifted;

    logic        fault_q,      fault_d;
    logic [63:0] fault_addr_q, fault_addr_d;
    logic        fault_wr_q,   fault_wr_d;

    // Address decode, range/alignment check and lane steering. The range
    // check is done on the full 64-bit offset so an address below BASE_ADDR
    // (which wraps to a huge offset) can never alias into the array.
    always_comb begin
        off      = data_mem_addr_i - BASE_ADDR;
        index    = off[AW+2:3];
        lane     = off[2:0];
        in_range = (data_mem_addr_i >= BASE_ADDR) && (off < SPAN);

        aligned   = 1'b1;
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        size_be   = 8'hFF;
        unique case (data_mem_byte_en_i)
            2'b00: begin
                aligned   = 1'b1;
                size_mask = 64'h0000_0000_0000_00FF;
                size_be   = 8'h01;
            end
            2'b01: begin
                aligned   = (lane[0] == 1'b0);
                size_mask = 64'h0000_0000_0000_FFFF;
                size_be   = 8'h03;
            end
            2'b10: begin
                aligned   = (lane[1:0] == 2'b00);
                size_mask = 64'h0000_0000_FFFF_FFFF;
                size_be   = 8'h0F;
            end
            2'b11: begin
                aligned   = (lane == 3'd0);
                size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                size_be   = 8'hFF;
            end
        endcase

        valid       = data_mem_req_i && in_range && aligned;
        load_valid  = valid && !data_mem_wr_i;
        store_valid = valid && data_mem_wr_i;
        fault_event = data_mem_req_i && !valid;

        // Alignment guarantees the shifted byte mask never spills past lane 7.
        wr_be      = size_be << lane;
        wr_shifted = data_mem_wr_data_i << {lane, 3'b000};
        rd_shifted = mem_q[index] >> {lane, 3'b000};

        data_mem_rd_data_o = 64'd0;
        if (load_valid) begin
            data_mem_rd_data_o = rd_shifted & size_mask;
        end
    end

    // Array write. Contents are not reset, but a store is dropped when reset
    // is held low at the edge so a reset mid-store leaves the word intact.
    always_ff @(posedge clk) begin
        if (reset_n && store_valid) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) begin
                    mem_q[index][8*b +: 8] <= wr_shifted[8*b +: 8];
                end
            end
        end
    end

    // First fault wins: capture only while the sticky flag is still clear.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        fault_wr_d   = fault_wr_q;
        if (fault_event && !fault_q) begin
            fault_d      = 1'b1;
            fault_addr_d = data_mem_addr_i;
            fault_wr_d   = data_mem_wr_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 64'd0;
            fault_wr_q   <= 1'b0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            fault_wr_q   <= fault_wr_d;
        end
    end

    assign fault_o      = fault_q;
    assign fault_addr_o = fault_addr_q;
    assign fault_wr_o   = fault_wr_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Saturating counters of accepted accesses; faults are not counted.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (load_valid && (rd_cnt_q != 32'hFFFF_FFFF)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (store_valid && (wr_cnt_q != 32'hFFFF_FFFF)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`else
    assign rd_cnt_o = 32'd0;
    assign wr_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed self-checking bench for data_mem_responder. Every access is driven
// on the falling edge, combinational read data is sampled just after the
// inputs settle, and registered outputs are sampled shortly after the rising
// edge. Expected counter values depend on whether DMEM_PERF_CNT_EN is set.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk;
    logic        reset_n;
    logic        req;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [63:0] wr_data;
    logic [63:0] rd_data;
    logic        fault;
    logic [63:0] fault_addr;
    logic        fault_wr;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int checksTotal  = 0;
    int checksPassed = 0;
    int expLoads     = 0;
    int expStores    = 0;
    logic [63:0] rdSample;

    data_mem_responder dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .data_mem_req_i     (req),
        .data_mem_addr_i    (addr),
        .data_mem_byte_en_i (size),
        .data_mem_wr_i      (wr),
        .data_mem_wr_data_i (wr_data),
        .data_mem_rd_data_o (rd_data),
        .fault_o            (fault),
        .fault_addr_o       (fault_addr),
        .fault_wr_o         (fault_wr),
        .rd_cnt_o           (rd_cnt),
        .wr_cnt_o           (wr_cnt)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checksTotal++;
        if (got === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // One request cycle: drive at the falling edge, sample the combinational
    // read data before the rising edge, then drop the request after it.
    task automatic applyStimulus(input logic isWr, input logic [1:0] sz, input logic [63:0] a,
                                 input logic [63:0] d, input bit expValid, output logic [63:0] rd);
        @(negedge clk);
        req     = 1'b1;
        wr      = isWr;
        size    = sz;
        addr    = a;
        wr_data = d;
        #1;
        rd = rd_data;
        @(posedge clk);
        #1;
        req = 1'b0;
        if (expValid) begin
            if (isWr) expStores++;
            else      expLoads++;
        end
    endtask

    task automatic checkCounters(input string tag);
        logic [63:0] expRd;
        logic [63:0] expWr;
`ifdef DMEM_PERF_CNT_EN
        expRd = 64'(expLoads);
        expWr = 64'(expStores);
`else
        expRd = 64'd0;
        expWr = 64'd0;
`endif
        checkOutput({tag, "_rd_cnt"}, 64'(rd_cnt), expRd);
        checkOutput({tag, "_wr_cnt"}, 64'(wr_cnt), expWr);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 1'b0;
        wr      = 1'b0;
        size    = 2'b00;
        addr    = 64'd0;
        wr_data = 64'd0;

        // Reset state.
        #2;
        checkOutput("reset_fault",      64'(fault), 64'd0);
        checkOutput("reset_fault_addr", fault_addr, 64'd0);
        checkOutput("reset_fault_wr",   64'(fault_wr), 64'd0);
        checkOutput("reset_rd_idle",    rd_data, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Dword store, then load back on the next cycle.
        applyStimulus(1'b1, 2'b11, 64'h10008, 64'h1122_3344_5566_7788, 1'b1, rdSample);
        checkOutput("store_rd_zero", rdSample, 64'd0);
        applyStimulus(1'b0, 2'b11, 64'h10008, 64'd0, 1'b1, rdSample);
        checkOutput("dword_load", rdSample, 64'h1122_3344_5566_7788);

        // Read data is zero whenever req is low, even for a valid address.
        @(negedge clk);
        addr = 64'h10008; size = 2'b11; wr = 1'b0;
        #1;
        checkOutput("req_low_rd_zero", rd_data, 64'd0);

        // Byte store merge; upper store-data bits must be ignored.
        applyStimulus(1'b1, 2'b11, 64'h10000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, rdSample);
        applyStimulus(1'b1, 2'b00, 64'h10003, 64'h1234_5678_9ABC_DEAB, 1'b1, rdSample);
        applyStimulus(1'b0, 2'b11, 64'h10000, 64'd0, 1'b1, rdSample);
        checkOutput("byte_merge_dword", rdSample, 64'hFFFF_FFFF_ABFF_FFFF);
        applyStimulus(1'b0, 2'b00, 64'h10003, 64'd0, 1'b1, rdSample);
        checkOutput("byte_load", rdSample, 64'h0000_0000_0000_00AB);

        // Word store in the upper half of a dword, then half/word/byte loads.
        applyStimulus(1'b1, 2'b10, 64'h10014, 64'hCAFE_BABE_DEAD_BEEF, 1'b1, rdSample);
        applyStimulus(1'b0, 2'b01, 64'h10016, 64'd0, 1'b1, rdSample);
        checkOutput("half_load", rdSample, 64'h0000_0000_0000_DEAD);
        applyStimulus(1'b0, 2'b10, 64'h10014, 64'd0, 1'b1, rdSample);
        checkOutput("word_load", rdSample, 64'h0000_0000_DEAD_BEEF);
        applyStimulus(1'b0, 2'b00, 64'h10017, 64'd0, 1'b1, rdSample);
        checkOutput("byte_hi_load", rdSample, 64'h0000_0000_0000_00DE);
        checkOutput("no_fault_yet", 64'(fault), 64'd0);

        // Misaligned word store faults and leaves memory unchanged.
        applyStimulus(1'b1, 2'b10, 64'h10006, 64'h5555_5555_5555_5555, 1'b0, rdSample);
        checkOutput("misalign_fault",      64'(fault), 64'd1);
        checkOutput("misalign_fault_addr", fault_addr, 64'h10006);
        checkOutput("misalign_fault_wr",   64'(fault_wr), 64'd1);
        applyStimulus(1'b0, 2'b11, 64'h10000, 64'd0, 1'b1, rdSample);
        checkOutput("misalign_no_write", rdSample, 64'hFFFF_FFFF_ABFF_FFFF);

        // Misaligned half load also faults with zero data.
        applyStimulus(1'b0, 2'b01, 64'h10001, 64'd0, 1'b0, rdSample);
        checkOutput("misalign_half_rd", rdSample, 64'd0);

        // Below-base load: zero data, first fault remains captured.
        applyStimulus(1'b0, 2'b11, 64'h0FFF8, 64'd0, 1'b0, rdSample);
        checkOutput("below_base_rd",    rdSample, 64'd0);
        checkOutput("first_fault_addr", fault_addr, 64'h10006);
        checkOutput("first_fault_wr",   64'(fault_wr), 64'd1);

        // Upper range boundary.
        applyStimulus(1'b1, 2'b11, 64'h11FF8, 64'hA5A5_0000_5A5A_1111, 1'b1, rdSample);
        applyStimulus(1'b0, 2'b11, 64'h11FF8, 64'd0, 1'b1, rdSample);
        checkOutput("last_word_load", rdSample, 64'hA5A5_0000_5A5A_1111);
        applyStimulus(1'b0, 2'b11, 64'h12000, 64'd0, 1'b0, rdSample);
        checkOutput("past_end_rd", rdSample, 64'd0);
        applyStimulus(1'b1, 2'b11, 64'h12000, 64'h0000_0000_0000_0BAD, 1'b0, rdSample);
        applyStimulus(1'b0, 2'b11, 64'h10000, 64'd0, 1'b1, rdSample);
        checkOutput("no_alias_word0", rdSample, 64'hFFFF_FFFF_ABFF_FFFF);
        checkOutput("held_fault_addr", fault_addr, 64'h10006);

        checkCounters("before_reset");

        // Asynchronous reset mid-cycle clears fault state and counters at once.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_fault",      64'(fault), 64'd0);
        checkOutput("async_fault_addr", fault_addr, 64'd0);
        checkOutput("async_fault_wr",   64'(fault_wr), 64'd0);
        expLoads  = 0;
        expStores = 0;
        checkCounters("after_reset");

        // Store presented while reset is held low across the edge is dropped.
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b11; addr = 64'h10008; wr_data = 64'h0000_0000_0000_DEAD;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 2'b11, 64'h10008, 64'd0, 1'b1, rdSample);
        checkOutput("reset_drops_store", rdSample, 64'h1122_3344_5566_7788);
        checkCounters("final");

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (memory side) for the core's data memory interface.
- Services the single-cycle load/store requests the core issues: combinational read and synchronous write into a 64-bit-wide word array.
- Performs byte-lane steering by size and offset, range and alignment checking, and sticky fault capture.
- Sits between the core's data port and the testbench/SoC memory map.

Parameters:
- BASE_ADDR, 64'h0000_0000_0001_0000, byte address of array word 0.
- DEPTH, 1024, number of 64-bit words; power of two, ≥2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- data_mem_req_i  in  1  access request this cycle
- data_mem_addr_i  in  64  byte address
- data_mem_byte_en_i  in  2  size: 00=byte, 01=half, 10=word, 11=dword
- data_mem_wr_i  in  1  1=store, 0=load
- data_mem_wr_data_i  in  64  store data, right-justified
- data_mem_rd_data_o  out  64  load data, right-justified, upper bits zero
- fault_o  out  1  sticky: a misaligned or out-of-range access occurred
- fault_addr_o  out  64  address of the first faulting access
- fault_wr_o  out  1  first fault was a store
- rd_cnt_o  out  32  accepted-load counter (optional feature)
- wr_cnt_o  out  32  accepted-store counter (optional feature)

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset_n low asynchronously clears fault_o, fault_addr_o, fault_wr_o, rd_cnt_o and wr_cnt_o to 0.
  - Array contents are not reset.
  - data_mem_rd_data_o is combinational and reads 0 whenever req is low.
- Decode:
  - off = addr − BASE_ADDR, computed 64-bit.
  - index = off[3+log2(DEPTH)−1:3]; lane = off[2:0]; size bytes N = 1 << byte_en.
- Valid access: req & in_range & aligned.
  - in_range: addr ≥ BASE_ADDR and off < DEPTH*8. Unsigned compare; no wrap-around. Addresses below BASE_ADDR are out of range.
  - aligned: lane mod N == 0 (half: lane[0]=0; word: lane[1:0]=0; dword: lane=0).
- Load (valid, wr=0), zero latency:
  - rd_data = (mem[index] >> 8*lane) masked to N bytes, upper bits 0.
  - Sign/zero extension is the core's job, not this block's.
- Store (valid, wr=1), applied at the next posedge:
  - Only lanes lane..lane+N−1 of mem[index] are updated, with wr_data bytes 0..N−1.
  - Other lanes are preserved.
  - rd_data during a store cycle = 0.
- Same-cycle read/write: a load in cycle T sees array state before any store committed at the end of T. A load in T+1 sees the T store.
- Faulting access (req & !valid):
  - No array update; rd_data = 0.
  - At the posedge: if fault_o==0, set fault_o=1 and capture fault_addr_o=addr, fault_wr_o=wr.
  - If fault_o is already 1, hold the captured values: first fault wins.
  - Only reset_n clears the fault state.
- req low: no state change. Inputs other than req are don't-care.
- Reset asserted mid-store: the store is dropped if reset_n is low at the edge. The array word is unmodified.

Optional Feature:
- Macro DMEM_PERF_CNT_EN.
- Defined:
  - rd_cnt_o increments on each valid load; wr_cnt_o increments on each valid store, at the posedge.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF.
  - Faulting accesses are not counted.
- Undefined: rd_cnt_o and wr_cnt_o are tied to 0 and no counter flops are instantiated. Ports remain present.

Test Plan:
- Dword store/load: store addr 0x10008, size 11, data 0x1122334455667788. Next-cycle load of the same address returns 0x1122334455667788.
- Byte store merge:
  - Preload 0x10000 with 0xFFFFFFFFFFFFFFFF.
  - Store byte 0xAB at 0x10003.
  - Dword load at 0x10000 returns 0xFFFFFFFFABFFFFFF.
  - Byte load at 0x10003 returns 0x00000000000000AB.
- Half/word steering: store word 0xDEADBEEF at 0x10014. Half load at 0x10016 returns 0x000000000000DEAD. Word load at 0x10014 returns 0x00000000DEADBEEF.
- Misalignment fault:
  - Word store at 0x10006 leaves memory unchanged.
  - fault_o=1, fault_addr_o=0x10006, fault_wr_o=1.
  - A later load at 0x0FFF8 (out of range) returns rd_data=0 and leaves fault_addr_o at 0x10006.
- Range boundary, DEPTH=1024:
  - Dword load at 0x11FF8 is valid.
  - Load at 0x12000 faults with rd_data=0.
  - Store at 0x12000 does not alias word 0.
- Reset/counters: with DMEM_PERF_CNT_EN, after 3 valid loads, 2 valid stores and 1 fault, rd_cnt_o=3 and wr_cnt_o=2. Asserting reset_n low mid-cycle immediately zeroes the counters and fault_o.
